tdm_mux: RTL

Time-division multiplexer: the sending end of the demultiplexer link. Merges CH input channels onto one shared data path and tags each word with its source channel index, so a downstream demultiplexer can drive its select input from that tag and route the word back out. Round-robin arbitration with valid/ready handshakes on every channel and a single registered output stage.

---
 rtl/tdm_mux.sv | 93 +++++++++
 1 files changed

// File: rtl/tdm_mux.sv
// Time-division multiplexer: round-robin merge of CH valid/ready channels onto one
// registered output stage, tagging each word with its source channel index.
module tdm_mux #(
    parameter int unsigned CH   = 4,
    parameter int unsigned W    = 8,
    parameter int unsigned SELW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH*W-1:0]   in_data,
    input  logic [CH-1:0]     in_valid,
    output logic [CH-1:0]     in_ready,
    output logic [W-1:0]      out_data,
    output logic [SELW-1:0]   out_sel,
    output logic              out_valid,
    input  logic              out_ready
);

    if (CH < 2 || CH > 8 || (1 << SELW) < CH) begin : g_bad_params
        $error("tdm_mux: CH must be 2..8 and 2**SELW >= CH");
    end

    // Pointer resets to the last channel so that channel 0 wins the first search.
    localparam logic [SELW-1:0] LastInit = SELW'(CH - 1);

    logic [W-1:0]    r_out_data;
    logic [SELW-1:0] r_out_sel;
    logic            r_out_valid;
    logic [SELW-1:0] r_last;

    logic            w_load_en;
    logic [CH-1:0]   w_grant;
    logic            w_found;
    logic [SELW-1:0] w_idx;
    logic [W-1:0]    w_data;

    assign w_load_en = !r_out_valid || out_ready;

    // Two ascending passes: channels above the pointer first, then wrap from channel 0.
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned k = 0; k < CH; k++) begin
            if (!w_found && in_valid[k] && (k > 32'(r_last))) begin
                w_grant[k] = 1'b1;
                w_found    = 1'b1;
                w_idx      = SELW'(k);
            end
        end
        for (int unsigned k = 0; k < CH; k++) begin
            if (!w_found && in_valid[k]) begin
                w_grant[k] = 1'b1;
                w_found    = 1'b1;
                w_idx      = SELW'(k);
            end
        end
    end

    always_comb begin
        w_data = '0;
        for (int unsigned k = 0; k < CH; k++) begin
            if (w_grant[k]) begin
                w_data = in_data[k*W +: W];
            end
        end
    end

    assign in_ready = (w_load_en && !rst) ? w_grant : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_out_valid <= 1'b0;
            r_last      <= LastInit;
        end else if (w_load_en) begin
            if (w_found) begin
                r_out_data  <= w_data;
                r_out_sel   <= w_idx;
                r_out_valid <= 1'b1;
                r_last      <= w_idx;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;

endmodule
